// File: rtl/a2f_stream_arbiter.sv
// a2f_stream_arbiter
//
// Packet scheduler that sits in front of the A2F FIFO on the FT600 write path.
// It merges two show-ahead source FIFOs into one framed word stream.
// Channel 0 carries IQ bursts of BURST_LEN words. Channel 1 carries
// control/status payloads of up to CTRL_MAX words.
// Each packet is one header word followed by its payload. The header is
// {8'hA5, seq[7:0], ch, len[14:0]}. A packet is only started when the sink
// has room for the whole packet, so a packet never stalls part-way through.
//
// Ports
//   clk, reset_n     clock, asynchronous active-low reset
//   enable           allows new packets to start; a packet in flight always completes
//   src0_data/level  channel-0 head word and word count
//   src0_rd          channel-0 pop (combinational)
//   src1_data/level  channel-1 head word and word count
//   src1_rd          channel-1 pop (combinational)
//   out_space        free words in the A2F FIFO
//   out_data/out_wr  registered word and write strobe into the A2F FIFO
//   busy             high while a packet is being emitted (header and payload)
//   pkt_count        completed packets, wraps at 16 bits
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no packet in flight; eligibility evaluated, header emitted on grant
// PAY   | payload words of the granted channel streamed one per cycle

module a2f_stream_arbiter #(
    parameter int DATA_W    = 32,
    parameter int LEVEL_W   = 12,
    parameter int BURST_LEN = 256,
    parameter int CTRL_MAX  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [DATA_W-1:0]  src0_data,
    input  logic [LEVEL_W-1:0] src0_level,
    output logic               src0_rd,
    input  logic [DATA_W-1:0]  src1_data,
    input  logic [LEVEL_W-1:0] src1_level,
    output logic               src1_rd,
    input  logic [LEVEL_W-1:0] out_space,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_wr,
    output logic               busy,
    output logic [15:0]        pkt_count
);

    typedef enum logic {
        IDLE = 1'b0,
        PAY  = 1'b1
    } state_t;

    localparam logic [31:0] BURST_W = 32'(BURST_LEN);
    localparam logic [31:0] CTRL_W  = 32'(CTRL_MAX);

    state_t      state;
    logic        grant_ch;
    logic        last_grant;
    logic [14:0] remaining;
    logic [7:0]  seq;

    // Level/space arithmetic is done at 32 bits so that len+1 cannot overflow
    // the LEVEL_W-wide inputs.
    logic [31:0] lvl0;
    logic [31:0] lvl1;
    logic [31:0] space;
    logic [31:0] ctrl_len;
    logic        elig0;
    logic        elig1;
    logic        can_start;
    logic        go;
    logic        pick;
    logic [14:0] hdr_len;

    assign lvl0     = 32'(src0_level);
    assign lvl1     = 32'(src1_level);
    assign space    = 32'(out_space);
    assign ctrl_len = (lvl1 > CTRL_W) ? CTRL_W : lvl1;

    assign elig0 = enable && (lvl0 >= BURST_W) && (space >= BURST_W + 32'd1);
    assign elig1 = enable && (lvl1 != 32'd0) && (space >= ctrl_len + 32'd1);

    // A grant is only allowed once out_wr has dropped. This forces one idle
    // cycle after every packet, which gives the neighbouring FIFOs a cycle to
    // update their level and space counters after the last pop and write.
    assign can_start = (state == IDLE) && !out_wr;
    assign go        = can_start && (elig0 || elig1);

    // If both channels are eligible, the channel that was not granted last
    // wins. If only one is eligible, that one wins.
    assign pick    = (elig0 && elig1) ? ~last_grant : elig1;
    assign hdr_len = pick ? ctrl_len[14:0] : BURST_W[14:0];

    // In PAY the head word is popped on the same edge that registers it onto
    // out_data.
    assign src0_rd = (state == PAY) && !grant_ch;
    assign src1_rd = (state == PAY) &&  grant_ch;

    // The header is registered on the IDLE->PAY edge. The header cycle
    // therefore already sees state == PAY.
    assign busy = (state == PAY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            out_data   <= '0;
            out_wr     <= 1'b0;
            grant_ch   <= 1'b0;
            last_grant <= 1'b1;
            remaining  <= '0;
            seq        <= '0;
            pkt_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        out_data   <= DATA_W'({8'hA5, seq, pick, hdr_len});
                        out_wr     <= 1'b1;
                        grant_ch   <= pick;
                        last_grant <= pick;
                        remaining  <= hdr_len;
                        state      <= PAY;
                    end else begin
                        out_wr <= 1'b0;
                    end
                end
                PAY: begin
                    out_data  <= grant_ch ? src1_data : src0_data;
                    out_wr    <= 1'b1;
                    remaining <= remaining - 15'd1;
                    if (remaining == 15'd1) begin
                        state     <= IDLE;
                        seq       <= seq + 8'd1;
                        pkt_count <= pkt_count + 16'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    out_wr <= 1'b0;
                end
            endcase
        end
    end

endmodule
